// File: rtl/mo_line_scanner_if.sv
// mo_line_scanner_if
//   Groups the scanner's bus signals into one bundle.
//   - start/line          : scan request from the line sequencer
//   - mo_a/mo_r/mo_do     : MORAM video read port (port 2), registered data
//   - desc_*              : descriptor stream to the line-buffer renderer
//   - busy/done/overflow  : scan status
//   Modport master is the scanner side; slave is the environment side
//   (sequencer, MORAM port 2 and renderer).
interface mo_line_scanner_if;
  logic        start;
  logic [7:0]  line;
  logic [7:0]  mo_a;
  logic        mo_r;
  logic [15:0] mo_do;
  logic        desc_valid;
  logic        desc_ready;
  logic [7:0]  desc_pic;
  logic [4:0]  desc_color;
  logic        desc_hflip;
  logic [7:0]  desc_x;
  logic [3:0]  desc_row;
  logic        busy;
  logic        done;
  logic        overflow;

  modport master (
    input  start, line, mo_do, desc_ready,
    output mo_a, mo_r, desc_valid, desc_pic, desc_color, desc_hflip,
           desc_x, desc_row, busy, done, overflow
  );

  modport slave (
    output start, line, mo_do, desc_ready,
    input  mo_a, mo_r, desc_valid, desc_pic, desc_color, desc_hflip,
           desc_x, desc_row, busy, done, overflow
  );
endinterface

// File: rtl/mo_line_scanner.sv
// mo_line_scanner
//   Per-scanline motion-object scanner. Walks objects 0..NUM_OBJ-1 through
//   the MORAM video read port, tests each against the requested line and
//   emits one descriptor per hit on a valid/ready stream, stopping early
//   once MAX_PER_LINE descriptors have been accepted.
//   Ports:
//     i_clk  : system clock, rising edge
//     i_rst  : asynchronous active-high reset
//     bus    : mo_line_scanner_if.master (request, MORAM port 2,
//              descriptor stream, status)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for start
//   RD_POS   | read word 2n+1 (y, x)
//   CHK_POS  | hit test on y; on a hit read word 2n (attributes)
//   CHK_ATTR | capture pic/color/hflip
//   OUT      | present descriptor until accepted
//   DONE     | one-cycle done pulse
module mo_line_scanner #(
  parameter int NUM_OBJ      = 128,
  parameter int MO_HEIGHT    = 16,
  parameter int MAX_PER_LINE = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  mo_line_scanner_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_POS   = 3'd1,
    S_CHK_POS  = 3'd2,
    S_CHK_ATTR = 3'd3,
    S_OUT      = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [6:0] LAST_N  = 7'(NUM_OBJ - 1);
  localparam logic [7:0] MAX_CNT = 8'(MAX_PER_LINE);
  localparam logic [7:0] HEIGHT  = 8'(MO_HEIGHT);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_line;
  logic [6:0]  r_n;
  logic [7:0]  r_cnt;
  logic        r_overflow;
  logic [7:0]  r_mo_a;

  logic [7:0]  r_pic;
  logic [4:0]  r_color;
  logic        r_hflip;
  logic [7:0]  r_x;
  logic [3:0]  r_row;

  logic [7:0]  w_row;
  logic        w_hit;
  logic        w_last;
  logic        w_cnt_full;
  logic [7:0]  w_mo_a;
  logic        w_mo_r;
  logic        w_n_inc;
  logic        w_cnt_inc;
  logic        w_ovf_set;
  logic        w_lat_pos;
  logic        w_lat_attr;
  logic        w_attr_unused;

  // Row inside the object; a line above y wraps to a large value and misses.
  assign w_row      = r_line - bus.mo_do[15:8];
  assign w_hit      = (w_row < HEIGHT);
  assign w_last     = (r_n == LAST_N);
  assign w_cnt_full = ((r_cnt + 8'd1) == MAX_CNT);

  // Attribute bits [7:6] carry nothing for this block.
  assign w_attr_unused = ^bus.mo_do[7:6];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mo_a      = r_mo_a;
    w_mo_r      = 1'b0;
    w_n_inc     = 1'b0;
    w_cnt_inc   = 1'b0;
    w_ovf_set   = 1'b0;
    w_lat_pos   = 1'b0;
    w_lat_attr  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_IDLE;
      end
      S_RD_POS: begin
        w_mo_a      = {r_n, 1'b1};
        w_mo_r      = 1'b1;
        w_state_nxt = S_CHK_POS;
      end
      S_CHK_POS: begin
        if (w_hit) begin
          w_lat_pos   = 1'b1;
          w_mo_a      = {r_n, 1'b0};
          w_mo_r      = 1'b1;
          w_state_nxt = S_CHK_ATTR;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_n_inc     = 1'b1;
          w_state_nxt = S_RD_POS;
        end
      end
      S_CHK_ATTR: begin
        w_lat_attr  = 1'b1;
        w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (bus.desc_ready) begin
          w_cnt_inc = 1'b1;
          if (w_cnt_full) begin
            w_ovf_set   = 1'b1;
            w_state_nxt = S_DONE;
          end else if (w_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_n_inc     = 1'b1;
            w_state_nxt = S_RD_POS;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A start at any time (re)launches the scan from object 0.
    if (bus.start) begin
      w_state_nxt = S_RD_POS;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_line     <= 8'd0;
      r_n        <= 7'd0;
      r_cnt      <= 8'd0;
      r_overflow <= 1'b0;
      r_mo_a     <= 8'd0;
    end else begin
      r_mo_a <= w_mo_a;
      if (bus.start) begin
        r_line     <= bus.line;
        r_n        <= 7'd0;
        r_cnt      <= 8'd0;
        r_overflow <= 1'b0;
      end else begin
        if (w_n_inc) begin
          r_n <= r_n + 7'd1;
        end
        if (w_cnt_inc) begin
          r_cnt <= r_cnt + 8'd1;
        end
        if (w_ovf_set) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pic   <= 8'd0;
      r_color <= 5'd0;
      r_hflip <= 1'b0;
      r_x     <= 8'd0;
      r_row   <= 4'd0;
    end else begin
      if (w_lat_pos) begin
        r_x   <= bus.mo_do[7:0];
        r_row <= w_row[3:0];
      end
      if (w_lat_attr) begin
        r_pic   <= bus.mo_do[15:8];
        r_hflip <= bus.mo_do[5];
        r_color <= bus.mo_do[4:0];
      end
    end
  end

  assign bus.mo_a       = w_mo_a;
  assign bus.mo_r       = w_mo_r;
  assign bus.desc_valid = (r_state == S_OUT);
  assign bus.desc_pic   = r_pic;
  assign bus.desc_color = r_color;
  assign bus.desc_hflip = r_hflip;
  assign bus.desc_x     = r_x;
  assign bus.desc_row   = r_row;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = (r_state == S_DONE);
  assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_mo_line_scanner.sv
module tb_mo_line_scanner;

  logic clk;
  logic rst;
  mo_line_scanner_if bus ();

  mo_line_scanner dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pic;
    logic [4:0] color;
    logic       hflip;
    logic [7:0] x;
    logic [3:0] row;
  } desc_t;

  logic [15:0] mem [256];
  int          cyc = 0;
  int          cyc_start = 0;
  int          first_valid = -1;
  int          done_cnt = 0;
  int          done_cyc = -1;
  logic [7:0]  addr_q [$];
  desc_t       desc_q [$];
  int          n_checks = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // MORAM port 2: registered read
  always @(posedge clk) begin
    if (bus.mo_r) bus.mo_do <= mem[bus.mo_a];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mo_r) addr_q.push_back(bus.mo_a);
      if (bus.desc_valid && bus.desc_ready)
        desc_q.push_back({bus.desc_pic, bus.desc_color, bus.desc_hflip,
                          bus.desc_x, bus.desc_row});
      if (bus.desc_valid && first_valid < 0) first_valid = cyc - cyc_start;
      if (bus.done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc - cyc_start;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) begin
      mem[2*i]   = 16'h0000;
      mem[2*i+1] = 16'h8000;
    end
  endtask

  task automatic clear_log();
    addr_q.delete();
    desc_q.delete();
    first_valid = -1;
    done_cyc = -1;
  endtask

  task automatic pulse_start(input logic [7:0] l);
    bus.start = 1'b1;
    bus.line  = l;
    cyc_start = cyc;
    first_valid = -1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(done_cnt - d0), 32'd1);
    tick();
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int k = 0;
    while (!bus.desc_valid && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(bus.desc_valid), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mo_a"},  32'(bus.mo_a), 32'd0);
    check({tag, "_mo_r"},  32'(bus.mo_r), 32'd0);
    check({tag, "_valid"}, 32'(bus.desc_valid), 32'd0);
    check({tag, "_desc"},  32'({bus.desc_pic, bus.desc_color, bus.desc_hflip,
                                bus.desc_x, bus.desc_row}), 32'd0);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_done"},  32'(bus.done), 32'd0);
    check({tag, "_ovf"},   32'(bus.overflow), 32'd0);
  endtask

  initial begin
    int bad;
    int a0;
    int d0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.line = 8'd0;
    bus.desc_ready = 1'b0;
    bus.mo_do = 16'd0;
    clear_mem();
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // all misses
    clear_log();
    bus.desc_ready = 1'b1;
    pulse_start(8'h10);
    wait_done(400, "t1_done_seen");
    check("t1_desc_cnt", 32'(desc_q.size()), 32'd0);
    check("t1_done_cyc", 32'(done_cyc), 32'd257);
    check("t1_ovf", 32'(bus.overflow), 32'd0);
    check("t1_addr_cnt", 32'(addr_q.size()), 32'd128);
    bad = 0;
    foreach (addr_q[k]) if (addr_q[k] !== 8'(2*k+1)) bad++;
    check("t1_addr_seq", 32'(bad), 32'd0);
    check("t1_busy_after", 32'(bus.busy), 32'd0);

    // single hit on object 5
    mem[10] = 16'h2A25;
    mem[11] = 16'h1040;
    clear_log();
    pulse_start(8'h13);
    wait_done(400, "t2_done_seen");
    check("t2_desc_cnt", 32'(desc_q.size()), 32'd1);
    if (desc_q.size() > 0) begin
      check("t2_pic",   32'(desc_q[0].pic), 32'h2A);
      check("t2_hflip", 32'(desc_q[0].hflip), 32'd1);
      check("t2_color", 32'(desc_q[0].color), 32'd5);
      check("t2_x",     32'(desc_q[0].x), 32'h40);
      check("t2_row",   32'(desc_q[0].row), 32'd3);
    end
    check("t2_valid_cyc", 32'(first_valid), 32'd14);
    check("t2_done_cyc", 32'(done_cyc), 32'd259);

    // wrap-around: y=250
    clear_mem();
    mem[4] = 16'h0107;
    mem[5] = 16'hFA11;
    clear_log();
    pulse_start(8'd3);
    wait_done(400, "t3a_done_seen");
    check("t3a_desc_cnt", 32'(desc_q.size()), 32'd1);
    if (desc_q.size() > 0) begin
      check("t3a_row", 32'(desc_q[0].row), 32'd9);
      check("t3a_x",   32'(desc_q[0].x), 32'h11);
      check("t3a_color", 32'(desc_q[0].color), 32'd7);
    end
    clear_log();
    pulse_start(8'd10);
    wait_done(400, "t3b_done_seen");
    check("t3b_desc_cnt", 32'(desc_q.size()), 32'd0);

    // backpressure: objects 1 and 3 hit at line 0x22
    clear_mem();
    mem[2] = 16'h3381;
    mem[3] = 16'h2055;
    mem[6] = 16'h44F6;
    mem[7] = 16'h1F66;
    clear_log();
    bus.desc_ready = 1'b0;
    pulse_start(8'h22);
    wait_valid(50, "t4_valid_seen");
    a0 = addr_q.size();
    for (int s = 0; s < 5; s++) begin
      check("t4_stall_valid", 32'(bus.desc_valid), 32'd1);
      check("t4_stall_mo_r",  32'(bus.mo_r), 32'd0);
      check("t4_stall_desc",  32'({bus.desc_pic, bus.desc_color, bus.desc_hflip,
                                   bus.desc_x, bus.desc_row}),
            32'({8'h33, 5'd1, 1'b0, 8'h55, 4'd2}));
      tick();
    end
    check("t4_stall_reads", 32'(addr_q.size() - a0), 32'd0);
    bus.desc_ready = 1'b1;
    wait_done(400, "t4_done_seen");
    check("t4_desc_cnt", 32'(desc_q.size()), 32'd2);
    if (desc_q.size() > 1) begin
      check("t4_desc0", 32'(desc_q[0]), 32'({8'h33, 5'd1, 1'b0, 8'h55, 4'd2}));
      check("t4_desc1", 32'(desc_q[1]), 32'({8'h44, 5'h16, 1'b1, 8'h66, 4'd3}));
    end

    // overflow: objects 0..19 hit at line 0x45, pic = n
    clear_mem();
    for (int i = 0; i < 20; i++) begin
      mem[2*i]   = {8'(i), 8'h00};
      mem[2*i+1] = {8'h40, 8'(8'h10 + i)};
    end
    clear_log();
    pulse_start(8'h45);
    wait_done(400, "t5_done_seen");
    check("t5_desc_cnt", 32'(desc_q.size()), 32'd16);
    bad = 0;
    foreach (desc_q[k]) if (desc_q[k].pic !== 8'(k) || desc_q[k].row !== 4'd5) bad++;
    check("t5_desc_order", 32'(bad), 32'd0);
    check("t5_done_cyc", 32'(done_cyc), 32'd65);
    check("t5_ovf", 32'(bus.overflow), 32'd1);
    repeat (10) tick();
    check("t5_ovf_held", 32'(bus.overflow), 32'd1);

    // restart while in OUT, then reset mid-scan
    clear_log();
    bus.desc_ready = 1'b0;
    pulse_start(8'h45);
    check("t6_ovf_clr", 32'(bus.overflow), 32'd0);
    wait_valid(50, "t6_valid_seen");
    check("t6_pic", 32'(bus.desc_pic), 32'h00);
    pulse_start(8'h45);
    check("t6_restart_valid", 32'(bus.desc_valid), 32'd0);
    check("t6_restart_mo_a",  32'(bus.mo_a), 32'd1);
    check("t6_restart_mo_r",  32'(bus.mo_r), 32'd1);
    check("t6_restart_busy",  32'(bus.busy), 32'd1);
    tick();
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check_all_zero("t6_reset");
    repeat (2) tick();
    rst = 1'b0;
    repeat (300) tick();
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6_idle_busy", 32'(bus.busy), 32'd0);
    check("t6_idle_valid", 32'(bus.desc_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
